// File: rtl/data_ram_arbiter.sv
// Arbiter and sequencer sharing the single data RAM port between the CPU
// load/store path and the external host port, with one-cycle read latency.
module data_ram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_size,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ram_read_flag,
    output logic              ram_write_flag,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic [2:0]        ram_write_size,
    input  logic [DATA_W-1:0] ram_read_data
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

    localparam logic       OWNER_CPU  = 1'b0;
    localparam logic       OWNER_EXT  = 1'b1;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        grant_cpu_s;
    logic        grant_ext_s;

    // State, read owner and starvation counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_CPU;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Arbitration, RAM command issue, read return and next-state logic
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        starve_cnt_d   = starve_cnt_q;
        grant_cpu_s    = 1'b0;
        grant_ext_s    = 1'b0;
        cpu_ack        = 1'b0;
        cpu_rdata      = '0;
        ext_ack        = 1'b0;
        ext_rdata      = '0;
        ram_read_flag  = 1'b0;
        ram_write_flag = 1'b0;
        ram_addr       = '0;
        ram_write_data = '0;
        ram_write_size = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (ext_req && (!cpu_req || (starve_cnt_q == STARVE_LIM))) begin
                    grant_ext_s = 1'b1;
                end else if (cpu_req) begin
                    grant_cpu_s = 1'b1;
                end else begin
                    grant_ext_s = 1'b0;
                end

                // Counter only grows while the host is actually waiting
                if (!ext_req || grant_ext_s) begin
                    starve_cnt_d = 4'd0;
                end else if (grant_cpu_s && (starve_cnt_q != 4'hF)) begin
                    starve_cnt_d = starve_cnt_q + 4'd1;
                end else begin
                    starve_cnt_d = starve_cnt_q;
                end

                if (grant_cpu_s) begin
                    ram_addr = cpu_addr;
                    if (cpu_we) begin
                        ram_write_flag = 1'b1;
                        ram_write_data = cpu_wdata;
                        ram_write_size = cpu_size;
                        cpu_ack        = 1'b1;
                    end else begin
                        ram_read_flag = 1'b1;
                        owner_d       = OWNER_CPU;
                        state_d       = ST_RD_WAIT;
                    end
                end else if (grant_ext_s) begin
                    ram_addr = ext_addr;
                    if (ext_we) begin
                        ram_write_flag = 1'b1;
                        ram_write_data = ext_wdata;
                        ram_write_size = SIZE_WORD;
                        ext_ack        = 1'b1;
                    end else begin
                        ram_read_flag = 1'b1;
                        owner_d       = OWNER_EXT;
                        state_d       = ST_RD_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (owner_q == OWNER_EXT) begin
                    ext_ack   = 1'b1;
                    ext_rdata = ram_read_data;
                end else begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = ram_read_data;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are forced quiet for the whole reset window, including
        // when reset lands in the middle of an outstanding read.
        if (!rst) begin
            cpu_ack        = 1'b0;
            cpu_rdata      = '0;
            ext_ack        = 1'b0;
            ext_rdata      = '0;
            ram_read_flag  = 1'b0;
            ram_write_flag = 1'b0;
            ram_addr       = '0;
            ram_write_data = '0;
            ram_write_size = 3'b000;
        end else begin
            cpu_ack = cpu_ack;
        end

        cpu_stall = cpu_req & ~cpu_ack;
    end

endmodule
